// File: rtl/spi_master_cfg.sv
// spi_master_cfg -- run-time configurable full-duplex SPI master.
//
// Frames of 1..DATA_W bits are exchanged with selectable CPOL/CPHA, bit order
// and SCK half-period (H = clk_div_i + 1 system clocks). SS can be held low
// across chained frames, and a frame can be aborted at any point.
//
// Ports:
//   spi_clk_i        system clock (rising edge)
//   spi_rst_i        synchronous active-low reset
//   spi_start_i      start request, honoured in IDLE or HOLD only
//   spi_abort_i      abort the current frame (ignored in IDLE)
//   spi_hold_i       keep SS low after this frame (sampled at end of TRAIL)
//   frame_len_i      frame length in bits, 0 = ignore start, >DATA_W clamped
//   clk_div_i        SCK half-period minus one
//   cpol_i, cpha_i   SPI mode
//   spi_fbo_i        1 = MSB first, 0 = LSB first
//   tx_data_i        transmit frame, right-aligned
//   MISO             serial input
//   SCK, MOSI, SS    serial clock, serial output, active-low select
//   spi_busy_o       frame in progress (LEAD/XFER/TRAIL)
//   done             one-cycle pulse when a frame completes
//   received_data_o  last completed frame, right-aligned, upper bits zero
module spi_master_cfg #(
    parameter int DATA_W = 80,
    parameter int LEN_W  = 7,
    parameter int DIV_W  = 8
) (
    input  logic              spi_clk_i,
    input  logic              spi_rst_i,
    input  logic              spi_start_i,
    input  logic              spi_abort_i,
    input  logic              spi_hold_i,
    input  logic [LEN_W-1:0]  frame_len_i,
    input  logic [DIV_W-1:0]  clk_div_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              spi_fbo_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              MISO,
    output logic              SCK,
    output logic              MOSI,
    output logic              SS,
    output logic              spi_busy_o,
    output logic              done,
    output logic [DATA_W-1:0] received_data_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_XFER, S_TRAIL, S_HOLD
    } state_t;

    state_t            r_state;
    logic [LEN_W-1:0]  r_len;
    logic [DIV_W-1:0]  r_div;
    logic              r_cpol;
    logic              r_cpha;
    logic              r_fbo;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DIV_W-1:0]  r_cnt;
    logic [LEN_W:0]    r_edge;   // SCK edges already driven in this frame

    // Wire position k -> data index under the latched bit order.
    function automatic logic [LEN_W-1:0] f_idx(input logic [LEN_W-1:0] k,
                                               input logic [LEN_W-1:0] len,
                                               input logic             fbo);
        return fbo ? (len - k - LEN_W'(1)) : k;
    endfunction

    logic [LEN_W-1:0] w_len_clamp;
    logic             w_abort;
    logic             w_accept;
    logic             w_tick;
    logic [LEN_W:0]   w_edge_n;
    logic             w_last;
    logic             w_sample;
    logic             w_shift;
    logic [LEN_W-1:0] w_is;
    logic [LEN_W-1:0] w_id;
    logic [LEN_W-1:0] w_first_idx;

    assign w_len_clamp = (int'(frame_len_i) > DATA_W) ? LEN_W'(DATA_W) : frame_len_i;
    assign w_abort     = spi_abort_i && (r_state != S_IDLE);
    // In IDLE a start is refused during the done cycle so SS gets at least one high cycle.
    assign w_accept    = spi_start_i && (frame_len_i != '0) && !w_abort &&
                         (((r_state == S_IDLE) && !done) || (r_state == S_HOLD));
    assign w_tick      = (r_cnt == r_div);
    assign w_edge_n    = r_edge + (LEN_W+1)'(1);
    assign w_last      = (w_edge_n == {r_len, 1'b0});
    // Odd edges sample for CPHA=0, even edges for CPHA=1; the other parity shifts,
    // except that CPHA=0 never shifts on the final edge.
    assign w_sample    = r_cpha ? ~w_edge_n[0] : w_edge_n[0];
    assign w_shift     = r_cpha ? w_edge_n[0] : (~w_edge_n[0] && !w_last);
    // Sampled bit and CPHA=1 driven bit are both k = r_edge/2; CPHA=0 drives k = edge/2.
    assign w_is        = f_idx(LEN_W'(r_edge >> 1), r_len, r_fbo);
    assign w_id        = r_cpha ? w_is : f_idx(LEN_W'(w_edge_n >> 1), r_len, r_fbo);
    assign w_first_idx = f_idx('0, w_len_clamp, spi_fbo_i);

    always_ff @(posedge spi_clk_i) begin
        if (!spi_rst_i) begin
            r_state         <= S_IDLE;
            r_len           <= '0;
            r_div           <= '0;
            r_cpol          <= 1'b0;
            r_cpha          <= 1'b0;
            r_fbo           <= 1'b0;
            r_tx            <= '0;
            r_rx            <= '0;
            r_cnt           <= '0;
            r_edge          <= '0;
            SCK             <= 1'b0;
            MOSI            <= 1'b1;
            SS              <= 1'b1;
            spi_busy_o      <= 1'b0;
            done            <= 1'b0;
            received_data_o <= '0;
        end else begin
            done <= 1'b0;
            if (w_abort) begin
                r_state    <= S_IDLE;
                SS         <= 1'b1;
                SCK        <= r_cpol;
                MOSI       <= 1'b1;
                spi_busy_o <= 1'b0;
            end else if (w_accept) begin
                r_state    <= S_LEAD;
                r_len      <= w_len_clamp;
                r_div      <= clk_div_i;
                r_cpol     <= cpol_i;
                r_cpha     <= cpha_i;
                r_fbo      <= spi_fbo_i;
                r_tx       <= tx_data_i;
                r_rx       <= '0;
                r_cnt      <= '0;
                r_edge     <= '0;
                SS         <= 1'b0;
                SCK        <= cpol_i;
                MOSI       <= cpha_i ? 1'b1 : tx_data_i[w_first_idx];
                spi_busy_o <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        SS   <= 1'b1;
                        SCK  <= r_cpol;
                        MOSI <= 1'b1;
                    end
                    S_LEAD, S_XFER: begin
                        if (w_tick) begin
                            r_cnt  <= '0;
                            r_edge <= w_edge_n;
                            SCK    <= ~SCK;
                            if (w_sample) r_rx[w_is] <= MISO;
                            if (w_shift)  MOSI <= r_tx[w_id];
                            r_state <= w_last ? S_TRAIL : S_XFER;
                        end else begin
                            r_cnt <= r_cnt + DIV_W'(1);
                        end
                    end
                    S_TRAIL: begin
                        if (w_tick) begin
                            r_cnt           <= '0;
                            done            <= 1'b1;
                            spi_busy_o      <= 1'b0;
                            MOSI            <= 1'b1;
                            received_data_o <= r_rx;
                            r_state         <= spi_hold_i ? S_HOLD : S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + DIV_W'(1);
                        end
                    end
                    S_HOLD: begin
                        MOSI <= 1'b1;
                        if (!spi_hold_i) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg -- directed self-checking bench for spi_master_cfg.
// A monitor counts SCK edges (with cycle stamps), captures MOSI at sample
// edges and acts as an SPI slave shifting a pattern onto MISO; MISO can be
// looped back to MOSI instead.
module tb_spi_master_cfg;

    localparam int DATA_W = 80;
    localparam int LEN_W  = 7;
    localparam int DIV_W  = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort_r;
    logic              hold;
    logic [LEN_W-1:0]  flen;
    logic [DIV_W-1:0]  div;
    logic              cpol;
    logic              cpha;
    logic              fbo;
    logic [DATA_W-1:0] tx;
    logic              SCK, MOSI, SS, busy, done;
    logic [DATA_W-1:0] rx;
    logic              w_miso;

    logic              lb;
    logic              s_miso;
    logic              s_cpha;
    logic [DATA_W-1:0] s_wire;
    logic [DATA_W-1:0] m_cap;
    int                s_k;
    int                e_cnt, e_first, e_last;
    int                done_cnt, ss_rise_cnt, ss_fall_cnt;
    logic              ss_q, sck_q;
    int                cyc, t0;
    int                checks, errors;

    assign w_miso = lb ? MOSI : s_miso;

    spi_master_cfg #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DIV_W(DIV_W)) dut (
        .spi_clk_i(clk), .spi_rst_i(rst_n), .spi_start_i(start),
        .spi_abort_i(abort_r), .spi_hold_i(hold), .frame_len_i(flen),
        .clk_div_i(div), .cpol_i(cpol), .cpha_i(cpha), .spi_fbo_i(fbo),
        .tx_data_i(tx), .MISO(w_miso), .SCK(SCK), .MOSI(MOSI), .SS(SS),
        .spi_busy_o(busy), .done(done), .received_data_o(rx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        ss_q = 1'b1; sck_q = 1'b0; s_k = 0; s_miso = 1'b0;
        e_cnt = 0; e_first = 0; e_last = 0;
        done_cnt = 0; ss_rise_cnt = 0; ss_fall_cnt = 0;
    end

    // Monitor/slave, sampled 2 time units after each rising edge.
    always begin
        @(posedge clk);
        #2;
        if (done === 1'b1) done_cnt++;
        if (SS === 1'b1 && ss_q === 1'b0) ss_rise_cnt++;
        if (SS === 1'b0 && ss_q === 1'b1) begin
            ss_fall_cnt++;
            s_k    = 0;
            s_miso = s_cpha ? 1'b0 : s_wire[0];
        end else if (SS === 1'b0 && SCK !== sck_q) begin
            e_cnt++;
            if (e_cnt == 1) e_first = cyc;
            e_last = cyc;
            if ((e_cnt % 2) != int'(s_cpha)) begin
                if ((e_cnt - 1) / 2 < DATA_W) m_cap[(e_cnt - 1) / 2] = MOSI;
            end else if (s_cpha) begin
                if (s_k < DATA_W) s_miso = s_wire[s_k];
                s_k++;
            end else begin
                s_k++;
                if (s_k < DATA_W) s_miso = s_wire[s_k];
            end
        end
        ss_q  = SS;
        sck_q = SCK;
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: that cycle is cycle 0; returns at the negedge of cycle 1.
    task automatic start_frame(input int len, input int dv, input logic pol,
                               input logic pha, input logic bo,
                               input logic [DATA_W-1:0] data);
        flen   = LEN_W'(len);
        div    = DIV_W'(dv);
        cpol   = pol;
        cpha   = pha;
        fbo    = bo;
        tx     = data;
        s_cpha = pha;
        e_cnt  = 0;
        m_cap  = '0;
        start  = 1'b1;
        t0     = cyc;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        dc = (done === 1'b1) ? (cyc - t0) : -1;
    endtask

    int dc, base_done, base_rise, base_fall;

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; abort_r = 1'b0; hold = 1'b0;
        flen = '0; div = '0; cpol = 1'b0; cpha = 1'b0; fbo = 1'b0; tx = '0;
        lb = 1'b0; s_cpha = 1'b0; s_wire = '0; m_cap = '0; t0 = 0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_SS", SS, 1);
        chk("rst_SCK", SCK, 0);
        chk("rst_MOSI", MOSI, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx", rx, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Mode 0, MSB first, len 8, div 0, loopback
        lb = 1'b1;
        start_frame(8, 0, 0, 0, 1, 80'hA5);
        chk("m0_SS_c1", SS, 0);
        chk("m0_busy_c1", busy, 1);
        wait_done(40, dc);
        chk("m0_done_cyc", dc, 18);
        chk("m0_busy_done", busy, 0);
        chk("m0_rx", rx, 80'hA5);
        chk("m0_edges", e_cnt, 16);
        chk("m0_first_edge", e_first - t0, 2);
        chk("m0_last_edge", e_last - t0, 17);
        chk("m0_SS_done", SS, 0);
        @(negedge clk);
        chk("m0_SS_after", SS, 1);
        chk("m0_MOSI_idle", MOSI, 1);
        chk("m0_SCK_idle", SCK, 0);

        // Mode 3, LSB first, len 80, div 3, slave pattern
        lb = 1'b0;
        s_wire = 80'hDEAD_BEEF_CAFE_1234_5A5A;
        start_frame(80, 3, 1, 1, 0, 80'h0123_4567_89AB_CDEF_F00D);
        chk("m3_SCK_c1", SCK, 1);
        wait_done(700, dc);
        chk("m3_done_cyc", dc, 645);
        chk("m3_edges", e_cnt, 160);
        chk("m3_first_edge", e_first - t0, 5);
        chk("m3_last_edge", e_last - t0, 641);
        chk("m3_rx", rx, 80'hDEAD_BEEF_CAFE_1234_5A5A);
        chk("m3_mosi_order", m_cap, 80'h0123_4567_89AB_CDEF_F00D);
        @(negedge clk);
        chk("m3_SCK_idle", SCK, 1);
        @(negedge clk);

        // Hold chaining, two len 16 frames, loopback
        lb = 1'b1;
        base_done = done_cnt;
        base_rise = ss_rise_cnt;
        hold = 1'b1;
        start_frame(16, 1, 0, 0, 1, 80'h1234);
        wait_done(100, dc);
        chk("hold_done1_cyc", dc, 67);
        chk("hold_rx1", rx, 80'h1234);
        chk("hold_SS_done1", SS, 0);
        hold = 1'b0;
        start_frame(16, 1, 0, 0, 1, 80'hBEEF);
        chk("hold_SS_f2c1", SS, 0);
        chk("hold_busy_f2c1", busy, 1);
        wait_done(100, dc);
        chk("hold_done2_cyc", dc, 67);
        chk("hold_rx2", rx, 80'hBEEF);
        chk("hold_no_rise", ss_rise_cnt - base_rise, 0);
        @(negedge clk);
        chk("hold_SS_after", SS, 1);
        chk("hold_one_rise", ss_rise_cnt - base_rise, 1);
        chk("hold_done_pulses", done_cnt - base_done, 2);
        @(negedge clk);

        // Abort at SCK edge 5 of a len 32 frame, mode 2
        lb = 1'b0;
        s_wire = 80'hFFFF_0000_FFFF_0000_FFFF;
        base_done = done_cnt;
        start_frame(32, 2, 1, 0, 1, 80'h8765_4321);
        repeat (15) @(negedge clk);
        chk("abt_edges_at5", e_cnt, 5);
        abort_r = 1'b1;
        @(negedge clk);
        abort_r = 1'b0;
        chk("abt_SS", SS, 1);
        chk("abt_SCK", SCK, 1);
        chk("abt_busy", busy, 0);
        chk("abt_MOSI", MOSI, 1);
        repeat (120) @(negedge clk);
        chk("abt_no_done", done_cnt - base_done, 0);
        chk("abt_rx_kept", rx, 80'hBEEF);
        chk("abt_no_more_edges", e_cnt, 5);

        // Synchronous reset mid-XFER
        start_frame(24, 0, 1, 0, 1, 80'hC3_5A3C);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_SS", SS, 1);
        chk("mrst_SCK", SCK, 0);
        chk("mrst_MOSI", MOSI, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_rx", rx, 0);
        repeat (40) @(negedge clk);
        chk("mrst_no_done", done_cnt - base_done, 0);

        // len 0 start is ignored
        base_fall = ss_fall_cnt;
        start_frame(0, 0, 0, 0, 1, 80'hFF);
        chk("len0_busy", busy, 0);
        repeat (6) @(negedge clk);
        chk("len0_no_SS_fall", ss_fall_cnt - base_fall, 0);
        chk("len0_SS", SS, 1);

        // Start pulses and config changes during a frame are ignored
        s_wire = 80'hFFFF_FFFF_FFFF_FFFF_F3A5;
        base_done = done_cnt;
        start_frame(12, 1, 0, 0, 1, 80'hABC);
        flen = 7'd40; div = 8'd0; cpol = 1'b1; cpha = 1'b1; fbo = 1'b0;
        tx = 80'h5555_5555_5555;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100, dc);
        chk("cfg_done_cyc", dc, 51);
        chk("cfg_edges", e_cnt, 24);
        chk("cfg_last_edge", e_last - t0, 49);
        chk("cfg_rx", rx, 80'hA5C);
        chk("cfg_mosi", m_cap, 80'h3D5);
        @(negedge clk);
        chk("cfg_SCK_idle", SCK, 0);
        chk("cfg_one_done", done_cnt - base_done, 1);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
